// File: rtl/aes_text_sequencer.sv
// aes_text_sequencer
//    Upstream control stage for the AES-128 encryption datapath. It holds a
//    plaintext buffer and issues one block at a time to the encryption core.
//    After each block it waits for the core's finish pulse. It drives the
//    block index shared with the cyphertext RAM, counts blocks, flags the end
//    of a run, and traps a hung core with a watchdog.
//
// Ports
//    clk_i          clock, all logic on the rising edge
//    rst_i          synchronous reset, active-high
//    load_en_i      plaintext buffer write strobe (honoured only when not busy)
//    load_addr_i    buffer write address (addresses >= MEMORY_SIZE dropped)
//    load_data_i    buffer write data
//    go_i           start a run (sampled in IDLE/DONE/ERROR only)
//    num_blocks_i   blocks in the run, latched and clamped on an accepted go_i
//    finish_i       core finish pulse (only honoured in WAIT)
//    pc_o           current block index, to core and cyphertext RAM
//    plaintext_o    block presented to the core
//    start_o        one-cycle core start pulse
//    busy_o         high in FETCH/ISSUE/WAIT
//    done_o         one-cycle pulse at the end of a run
//    timeout_err_o  sticky watchdog error
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for go_i; buffer writable
// FETCH  | buffer[pc_o] read, plaintext_o registered on exit
// ISSUE  | start_o high for one cycle, watchdog armed
// WAIT   | waiting for finish_i; watchdog counting down
// DONE   | done_o high for one cycle; go_i accepted as in IDLE
// ERROR  | watchdog expired; timeout_err_o held until reset or next run

module aes_text_sequencer #(
   parameter int TEXT_WIDTH     = 128,
   parameter int ADDR_WIDTH     = 4,
   parameter int MEMORY_SIZE    = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_en_i,
   input  logic [ADDR_WIDTH-1:0] load_addr_i,
   input  logic [TEXT_WIDTH-1:0] load_data_i,
   input  logic                  go_i,
   input  logic [ADDR_WIDTH:0]   num_blocks_i,
   input  logic                  finish_i,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic [TEXT_WIDTH-1:0] plaintext_o,
   output logic                  start_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  timeout_err_o
);

   // The watchdog is a down-counter loaded with TIMEOUT_CYCLES-2 when the
   // block is issued. Terminal count zero in WAIT without finish_i is the
   // cycle where an up-count from zero would reach TIMEOUT_CYCLES-1. That
   // puts the error flag exactly TIMEOUT_CYCLES cycles after start_o.
   localparam int WD_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES - 1) : 1;
   localparam logic [WD_WIDTH-1:0]   WD_LOAD  = WD_WIDTH'(TIMEOUT_CYCLES - 2);
   localparam logic [WD_WIDTH-1:0]   WD_ONE   = 1;
   localparam logic [ADDR_WIDTH-1:0] PC_ONE   = 1;
   localparam logic [ADDR_WIDTH:0]   N_ONE    = 1;
   localparam logic [ADDR_WIDTH:0]   N_MAX    = (ADDR_WIDTH + 1)'(MEMORY_SIZE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH:0]   n_blocks;
   logic [WD_WIDTH-1:0]   wd_cnt;
   logic [TEXT_WIDTH-1:0] mem [MEMORY_SIZE];

   logic                  idle_like;
   logic                  go_accept;
   logic                  wr_en;
   logic                  last_blk;
   logic [ADDR_WIDTH:0]   n_clamped;

   assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
   assign go_accept = idle_like && go_i && (num_blocks_i != '0);
   assign wr_en     = idle_like && load_en_i && (int'(load_addr_i) < MEMORY_SIZE);
   assign n_clamped = (num_blocks_i > N_MAX) ? N_MAX : num_blocks_i;
   assign last_blk  = ({1'b0, pc_o} == (n_blocks - N_ONE));

   // Buffer contents deliberately have no reset so this maps onto RAM.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[load_addr_i] <= load_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= S_IDLE;
         pc_o          <= '0;
         plaintext_o   <= '0;
         start_o       <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         timeout_err_o <= 1'b0;
         wd_cnt        <= '0;
         n_blocks      <= '0;
      end else begin
         start_o <= 1'b0;
         done_o  <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (go_accept) begin
                  n_blocks      <= n_clamped;
                  pc_o          <= '0;
                  timeout_err_o <= 1'b0;
                  busy_o        <= 1'b1;
                  state         <= S_FETCH;
               end else if (state == S_DONE) begin
                  state <= S_IDLE;
               end
            end
            S_FETCH: begin
               plaintext_o <= mem[pc_o];
               start_o     <= 1'b1;
               state       <= S_ISSUE;
            end
            S_ISSUE: begin
               wd_cnt <= WD_LOAD;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               // A finish in the terminal-count cycle wins over the timeout.
               if (finish_i) begin
                  if (last_blk) begin
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     pc_o  <= pc_o + PC_ONE;
                     state <= S_FETCH;
                  end
               end else if (wd_cnt == '0) begin
                  timeout_err_o <= 1'b1;
                  busy_o        <= 1'b0;
                  state         <= S_ERROR;
               end else begin
                  wd_cnt <= wd_cnt - WD_ONE;
               end
            end
            default: begin
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/aes_text_sequencer.md
Name: aes_text_sequencer

Overview:
Upstream control stage for the AES-128 encryption datapath. Holds a plaintext buffer, issues one 128-bit block at a time to the encryption core and waits for the core's finish pulse. It drives the block address (pc) shared with the cyphertext RAM, so each cyphertext lands at the same index as its plaintext. It also counts blocks, flags completion, and traps a hung core with a watchdog.

Parameters:
TEXT_WIDTH, 128, plaintext/cyphertext block width
ADDR_WIDTH, 4, block address width
MEMORY_SIZE, 16, buffer depth in blocks (≤ 2^ADDR_WIDTH)
TIMEOUT_CYCLES, 64, max cycles in WAIT before error

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
load_en_i  in  1  plaintext buffer write strobe
load_addr_i  in  ADDR_WIDTH  buffer write address
load_data_i  in  TEXT_WIDTH  buffer write data
go_i  in  1  start a run (sampled in IDLE/DONE/ERROR only)
num_blocks_i  in  ADDR_WIDTH+1  blocks in run, latched on accepted go_i
finish_i  in  1  core finish pulse (same net as cyphertext RAM finish_d)
pc_o  out  ADDR_WIDTH  current block index, to core and cyphertext RAM
plaintext_o  out  TEXT_WIDTH  block presented to core
start_o  out  1  one-cycle core start pulse
busy_o  out  1  high in FETCH/ISSUE/WAIT
done_o  out  1  one-cycle pulse at end of run
timeout_err_o  out  1  sticky watchdog error

Behaviour:
- Reset: state=IDLE; pc_o=0; plaintext_o=0; start_o=0; busy_o=0; done_o=0; timeout_err_o=0; watchdog=0; latched count=0. Buffer contents not reset.
- Buffer: synchronous write when load_en_i and state==IDLE/DONE/ERROR; writes during busy_o dropped. Addresses ≥ MEMORY_SIZE dropped. Read is registered, 1-cycle latency.
- States: IDLE, FETCH, ISSUE, WAIT, DONE, ERROR.
- IDLE: if go_i and num_blocks_i≠0, latch N=min(num_blocks_i, MEMORY_SIZE), pc_o←0, clear timeout_err_o, go to FETCH. go_i with num_blocks_i=0: remain IDLE, no done_o pulse.
- FETCH (1 cycle): buffer[pc_o] read; plaintext_o registered at exit. Go to ISSUE.
- ISSUE (1 cycle): start_o=1, plaintext_o stable. Go to WAIT, watchdog←0.
- WAIT: plaintext_o and pc_o held stable. On finish_i:
  - if pc_o==N-1, go to DONE; pc_o holds.
  - else pc_o←pc_o+1 and go to FETCH.
  - pc_o updates on the same edge that the cyphertext RAM samples it, so the RAM stores at the old index.
  - Without finish_i, watchdog+1. When the watchdog reaches TIMEOUT_CYCLES-1 with no finish_i, set timeout_err_o=1 and go to ERROR.
  - finish_i in the same cycle as the watchdog limit: treated as finish (no error).
- DONE: done_o=1 for exactly one cycle, then IDLE. go_i in DONE is accepted as in IDLE, and done_o still pulses.
- ERROR: busy_o=0; timeout_err_o held until reset or accepted go_i (same rules as IDLE).
- finish_i outside WAIT: ignored. go_i while busy_o: ignored.
- Pacing: per-block overhead is 2 cycles (FETCH+ISSUE) plus core latency. Minimum gap finish→next start_o = 2 cycles.
- Reset mid-run: next cycle all outputs at reset values. The core must be reset alongside, and no further start_o is issued.
- pc_o never exceeds N-1, no wrap-around inside a run.

Test Plan:
- Load buffer[0..3]=128'h0..0, 128'h11..11, 128'h22..22, 128'h33..33; go_i with N=4; core model finishes 10 cycles after start_o → four start_o pulses, pc_o=0,1,2,3 at each finish, plaintext_o matches buffer, done_o one cycle after final finish, busy_o low afterward.
- Core model never asserts finish_i, N=1 → timeout_err_o=1 exactly TIMEOUT_CYCLES cycles after start_o, state ERROR. go_i with N=1 clears the error and restarts.
- Finish_i arriving in the same cycle as the watchdog limit → no error, run completes, done_o pulses.
- go_i with N=0 → no start_o and no done_o. N=20 (>16) → exactly 16 blocks processed, last pc_o=15.
- load_en_i and go_i pulsed during WAIT → buffer unchanged (readback in next run), no second run started.
- rst_i asserted in WAIT of block 2 → next cycle pc_o=0, busy_o=0, start_o=0. Stray finish_i afterwards is ignored.
